// File: rtl/program_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the core's instruction decoder.
// Holds the loader state encoding, the instruction field layout and a word-packing helper.
package program_loader_pkg;

  localparam int DATA_WIDTH    = 18;
  localparam int OP_WIDTH      = 2;
  localparam int OPERAND_WIDTH = 8;
  localparam int OP_MSB        = 17;
  localparam int OP1_MSB       = 15;
  localparam int OP2_MSB       = 7;

  typedef enum logic [2:0] {
    S_HDR_HI = 3'd0,
    S_HDR_LO = 3'd1,
    S_OPC    = 3'd2,
    S_OP1    = 3'd3,
    S_OP2    = 3'd4,
    S_WRITE  = 3'd5,
    S_DONE   = 3'd6,
    S_ERROR  = 3'd7
  } loader_state_t;

  function automatic logic [DATA_WIDTH-1:0] pack_instr(
    input logic [OP_WIDTH-1:0]      op,
    input logic [OPERAND_WIDTH-1:0] operand1,
    input logic [OPERAND_WIDTH-1:0] operand2
  );
    logic [DATA_WIDTH-1:0] word;
    word = '0;
    word[OP_MSB -: OP_WIDTH]       = op;
    word[OP1_MSB -: OPERAND_WIDTH] = operand1;
    word[OP2_MSB -: OPERAND_WIDTH] = operand2;
    return word;
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input, instruction-memory write port and core control lines of the loader.
// The master modport is the loader; the slave modport is the host/memory/core side.
interface program_loader_if #(
  parameter int ADDRESS_WIDTH = 10
);
  import program_loader_pkg::*;

  logic [7:0]               In_Data;
  logic                     In_Valid;
  logic                     In_Ready;
  logic                     Mem_Write_Enable;
  logic [ADDRESS_WIDTH-1:0] Mem_Address;
  logic [DATA_WIDTH-1:0]    Mem_Write_Data;
  logic                     Core_Reset;
  logic                     Done;
  logic                     Error;

  modport master (
    input  In_Data, In_Valid,
    output In_Ready, Mem_Write_Enable, Mem_Address, Mem_Write_Data,
    output Core_Reset, Done, Error
  );

  modport slave (
    output In_Data, In_Valid,
    input  In_Ready, Mem_Write_Enable, Mem_Address, Mem_Write_Data,
    input  Core_Reset, Done, Error
  );
endinterface

// File: rtl/program_loader.sv
// Assembles a counted byte stream into 18-bit instructions and writes them to instruction
// memory, holding the core in reset until the whole program has been loaded.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// HDR_HI   | waiting for instruction-count high byte
// HDR_LO   | waiting for instruction-count low byte, range-checks count
// OPC      | waiting for opcode byte (upper six bits must be zero)
// OP1      | waiting for operand 1 byte
// OP2      | waiting for operand 2 byte
// WRITE    | one-cycle memory write strobe, advance index
// DONE     | program loaded, core released (terminal)
// ERROR    | malformed stream (terminal)
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 10
) (
  input  logic              CLK,
  input  logic              Reset,
  program_loader_if.master  bus
);

  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDRESS_WIDTH;

  loader_state_t            state, state_next;
  logic [15:0]              count, count_next;
  logic [ADDRESS_WIDTH-1:0] index, index_next;
  logic [OP_WIDTH-1:0]      op_hold, op_hold_next;
  logic [7:0]               op1_hold, op1_hold_next;
  logic [ADDRESS_WIDTH-1:0] mem_addr, mem_addr_next;
  logic [DATA_WIDTH-1:0]    mem_data, mem_data_next;
  logic                     mem_we, core_reset, done, error;

  logic                     ready;
  logic                     accept;
  logic [15:0]              hdr_count;
  logic                     last_word;

  assign ready = (state == S_HDR_HI) || (state == S_HDR_LO) || (state == S_OPC) ||
                 (state == S_OP1)    || (state == S_OP2);
  assign accept    = ready && bus.In_Valid;
  assign hdr_count = {count[15:8], bus.In_Data};
  assign last_word = ({{(16-ADDRESS_WIDTH){1'b0}}, index} == (count - 16'd1));

  always_comb begin
    state_next    = state;
    count_next    = count;
    index_next    = index;
    op_hold_next  = op_hold;
    op1_hold_next = op1_hold;
    mem_addr_next = mem_addr;
    mem_data_next = mem_data;
    case (state)
      S_HDR_HI: if (accept) begin
        count_next = {bus.In_Data, count[7:0]};
        state_next = S_HDR_LO;
      end
      S_HDR_LO: if (accept) begin
        count_next = hdr_count;
        if (hdr_count == 16'd0)                 state_next = S_DONE;
        else if ({1'b0, hdr_count} > MAX_WORDS) state_next = S_ERROR;
        else begin
          index_next = '0;
          state_next = S_OPC;
        end
      end
      S_OPC: if (accept) begin
        if (bus.In_Data[7:2] != 6'd0) state_next = S_ERROR;
        else begin
          op_hold_next = bus.In_Data[1:0];
          state_next   = S_OP1;
        end
      end
      S_OP1: if (accept) begin
        op1_hold_next = bus.In_Data;
        state_next    = S_OP2;
      end
      S_OP2: if (accept) begin
        mem_addr_next = index;
        mem_data_next = pack_instr(op_hold, op1_hold, bus.In_Data);
        state_next    = S_WRITE;
      end
      S_WRITE: begin
        if (last_word) state_next = S_DONE;
        else begin
          index_next = index + 1'b1;
          state_next = S_OPC;
        end
      end
      default: state_next = state;
    endcase
  end

  // Status outputs are registered from the next state so they line up with the state flop.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= S_HDR_HI;
      count      <= '0;
      index      <= '0;
      op_hold    <= '0;
      op1_hold   <= '0;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_we     <= 1'b0;
      core_reset <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      index      <= index_next;
      op_hold    <= op_hold_next;
      op1_hold   <= op1_hold_next;
      mem_addr   <= mem_addr_next;
      mem_data   <= mem_data_next;
      mem_we     <= (state_next == S_WRITE);
      core_reset <= (state_next != S_DONE);
      done       <= (state_next == S_DONE);
      error      <= (state_next == S_ERROR);
    end
  end

  assign bus.In_Ready         = ready;
  assign bus.Mem_Write_Enable = mem_we;
  assign bus.Mem_Address      = mem_addr;
  assign bus.Mem_Write_Data   = mem_data;
  assign bus.Core_Reset       = core_reset;
  assign bus.Done             = done;
  assign bus.Error            = error;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: per-cycle vector table on a 10-bit-address instance plus
// hand sequences for count range limits (2-bit-address instance) and reset mid-load.
module tb_program_loader;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [7:0]  data;
    logic        rdy;
    logic        we;
    logic [9:0]  addr;
    logic [17:0] wd;
    logic        cr;
    logic        dn;
    logic        er;
  } vec_t;

  logic clk = 1'b0;
  logic rst0, rst1;
  int   n_vec = 0;
  int   n_miss = 0;

  logic [9:0]  wr_addr0[$];
  logic [17:0] wr_data0[$];
  int          wr_cnt1 = 0;

  always #5 clk = ~clk;

  program_loader_if #(.ADDRESS_WIDTH(10)) bus0 ();
  program_loader_if #(.ADDRESS_WIDTH(2))  bus1 ();

  program_loader #(.ADDRESS_WIDTH(10)) dut0 (.CLK(clk), .Reset(rst0), .bus(bus0));
  program_loader #(.ADDRESS_WIDTH(2))  dut1 (.CLK(clk), .Reset(rst1), .bus(bus1));

  always @(negedge clk) begin
    if (bus0.Mem_Write_Enable === 1'b1) begin
      wr_addr0.push_back(bus0.Mem_Address);
      wr_data0.push_back(bus0.Mem_Write_Data);
    end
    if (bus1.Mem_Write_Enable === 1'b1) wr_cnt1++;
  end

  function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d,
                              input logic rdy, input logic we, input logic [9:0] a,
                              input logic [17:0] w, input logic cr, input logic dn,
                              input logic er);
    vec_t x;
    x.rst = r; x.valid = v; x.data = d; x.rdy = rdy; x.we = we;
    x.addr = a; x.wd = w; x.cr = cr; x.dn = dn; x.er = er;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int  gap;
    bit  taken;
    gap = $urandom_range(0, 2);
    repeat (gap) begin
      bus0.In_Valid = 1'b0;
      bus0.In_Data  = 8'($urandom);
      @(negedge clk);
    end
    bus0.In_Valid = 1'b1;
    bus0.In_Data  = b;
    taken = 1'b0;
    for (int t = 0; t < 20 && !taken; t++) begin
      if (bus0.In_Ready === 1'b1) taken = 1'b1;
      @(negedge clk);
    end
    bus0.In_Valid = 1'b0;
    if (!taken) begin
      n_vec++;
      n_miss++;
      $display("FAIL send_byte timeout: byte %0h never accepted", b);
    end
  endtask

  vec_t tbl[36];

  initial begin
    bit ok;

    tbl[0]  = mk(0,1,8'h00, 1,0,0,0,       1,0,0);
    tbl[1]  = mk(0,1,8'h02, 1,0,0,0,       1,0,0);
    tbl[2]  = mk(0,1,8'h01, 1,0,0,0,       1,0,0);
    tbl[3]  = mk(0,1,8'h05, 1,0,0,0,       1,0,0);
    tbl[4]  = mk(0,1,8'h03, 1,0,0,0,       1,0,0);
    tbl[5]  = mk(0,1,8'h03, 0,1,0,18'h10503, 1,0,0);
    tbl[6]  = mk(0,1,8'h03, 1,0,0,0,       1,0,0);
    tbl[7]  = mk(0,1,8'hFF, 1,0,0,0,       1,0,0);
    tbl[8]  = mk(0,1,8'h0A, 1,0,0,0,       1,0,0);
    tbl[9]  = mk(0,0,8'h00, 0,1,1,18'h3FF0A, 1,0,0);
    tbl[10] = mk(0,1,8'h55, 0,0,0,0,       0,1,0);
    tbl[11] = mk(0,1,8'h55, 0,0,0,0,       0,1,0);
    tbl[12] = mk(1,0,8'h00, 0,0,0,0,       0,1,0);
    tbl[13] = mk(1,0,8'h00, 1,0,0,0,       1,0,0);
    tbl[14] = mk(0,1,8'h00, 1,0,0,0,       1,0,0);
    tbl[15] = mk(0,1,8'h00, 1,0,0,0,       1,0,0);
    tbl[16] = mk(0,0,8'h00, 0,0,0,0,       0,1,0);
    tbl[17] = mk(0,1,8'h00, 0,0,0,0,       0,1,0);
    tbl[18] = mk(1,0,8'h00, 0,0,0,0,       0,1,0);
    tbl[19] = mk(0,1,8'h00, 1,0,0,0,       1,0,0);
    tbl[20] = mk(0,1,8'h01, 1,0,0,0,       1,0,0);
    tbl[21] = mk(0,1,8'h04, 1,0,0,0,       1,0,0);
    tbl[22] = mk(0,1,8'h11, 0,0,0,0,       1,0,1);
    tbl[23] = mk(0,1,8'h22, 0,0,0,0,       1,0,1);
    tbl[24] = mk(1,0,8'h00, 0,0,0,0,       1,0,1);
    tbl[25] = mk(0,0,8'h00, 1,0,0,0,       1,0,0);
    tbl[26] = mk(0,1,8'h00, 1,0,0,0,       1,0,0);
    tbl[27] = mk(0,0,8'h77, 1,0,0,0,       1,0,0);
    tbl[28] = mk(0,1,8'h01, 1,0,0,0,       1,0,0);
    tbl[29] = mk(0,0,8'h00, 1,0,0,0,       1,0,0);
    tbl[30] = mk(0,1,8'h02, 1,0,0,0,       1,0,0);
    tbl[31] = mk(0,1,8'hAB, 1,0,0,0,       1,0,0);
    tbl[32] = mk(0,0,8'h00, 1,0,0,0,       1,0,0);
    tbl[33] = mk(0,1,8'hCD, 1,0,0,0,       1,0,0);
    tbl[34] = mk(0,0,8'h00, 0,1,0,18'h2ABCD, 1,0,0);
    tbl[35] = mk(0,0,8'h00, 0,0,0,0,       0,1,0);

    rst0 = 1'b1; rst1 = 1'b1;
    bus0.In_Valid = 1'b0; bus0.In_Data = 8'h00;
    bus1.In_Valid = 1'b0; bus1.In_Data = 8'h00;
    @(negedge clk); @(negedge clk);
    rst0 = 1'b0;

    check("reset Core_Reset", 32'(bus0.Core_Reset), 32'd1);
    check("reset Done", 32'(bus0.Done), 32'd0);
    check("reset Error", 32'(bus0.Error), 32'd0);
    check("reset Mem_Write_Enable", 32'(bus0.Mem_Write_Enable), 32'd0);
    check("reset In_Ready", 32'(bus0.In_Ready), 32'd1);

    for (int i = 0; i < 36; i++) begin
      ok = (bus0.In_Ready === tbl[i].rdy) && (bus0.Mem_Write_Enable === tbl[i].we) &&
           (bus0.Core_Reset === tbl[i].cr) && (bus0.Done === tbl[i].dn) &&
           (bus0.Error === tbl[i].er);
      if (tbl[i].we)
        ok = ok && (bus0.Mem_Address === tbl[i].addr) && (bus0.Mem_Write_Data === tbl[i].wd);
      n_vec++;
      if (!ok) begin
        n_miss++;
        $display("FAIL vec%0d: got rdy=%b we=%b addr=%h wd=%h cr=%b done=%b err=%b, want rdy=%b we=%b addr=%h wd=%h cr=%b done=%b err=%b",
                 i, bus0.In_Ready, bus0.Mem_Write_Enable, bus0.Mem_Address, bus0.Mem_Write_Data,
                 bus0.Core_Reset, bus0.Done, bus0.Error, tbl[i].rdy, tbl[i].we, tbl[i].addr,
                 tbl[i].wd, tbl[i].cr, tbl[i].dn, tbl[i].er);
      end
      rst0          = tbl[i].rst;
      bus0.In_Valid = tbl[i].valid;
      bus0.In_Data  = tbl[i].data;
      @(negedge clk);
    end
    check("table total writes", 32'(wr_addr0.size()), 32'd3);

    // Count limit on a 4-word memory: 5 is rejected, 4 is accepted.
    rst1 = 1'b0;
    bus1.In_Valid = 1'b1; bus1.In_Data = 8'h00; @(negedge clk);
    bus1.In_Data = 8'h05; @(negedge clk);
    bus1.In_Valid = 1'b0; @(negedge clk);
    check("aw2 n5 Error", 32'(bus1.Error), 32'd1);
    check("aw2 n5 In_Ready", 32'(bus1.In_Ready), 32'd0);
    check("aw2 n5 Core_Reset", 32'(bus1.Core_Reset), 32'd1);
    check("aw2 n5 Done", 32'(bus1.Done), 32'd0);
    rst1 = 1'b1; @(negedge clk);
    rst1 = 1'b0;
    check("aw2 reset clears Error", 32'(bus1.Error), 32'd0);
    bus1.In_Valid = 1'b1; bus1.In_Data = 8'h00; @(negedge clk);
    bus1.In_Data = 8'h04; @(negedge clk);
    bus1.In_Valid = 1'b0; @(negedge clk);
    check("aw2 n4 Error", 32'(bus1.Error), 32'd0);
    check("aw2 n4 In_Ready", 32'(bus1.In_Ready), 32'd1);
    check("aw2 writes", 32'(wr_cnt1), 32'd0);

    // Reset after four bytes abandons the partial program, then a full N=1 load.
    wr_addr0.delete(); wr_data0.delete();
    rst0 = 1'b1; @(negedge clk); rst0 = 1'b0;
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h01); send_byte(8'h07);
    rst0 = 1'b1; @(negedge clk); @(negedge clk);
    rst0 = 1'b0;
    check("midload Core_Reset", 32'(bus0.Core_Reset), 32'd1);
    check("midload In_Ready", 32'(bus0.In_Ready), 32'd1);
    check("midload writes", 32'(wr_addr0.size()), 32'd0);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    repeat (3) @(negedge clk);
    check("reload writes", 32'(wr_addr0.size()), 32'd1);
    if (wr_addr0.size() > 0) begin
      check("reload addr", 32'(wr_addr0[0]), 32'd0);
      check("reload data", 32'(wr_data0[0]), 32'h21234);
    end
    check("reload Done", 32'(bus0.Done), 32'd1);
    check("reload Core_Reset", 32'(bus0.Core_Reset), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
